// File: rtl/alu_result_checker.sv
// In-line result checker for the serial ALU: queues expected results at issue,
// judges each response against the oldest expectation, and raises sticky alarms.
module alu_result_checker #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DATA_W-1:0]          req_a,
  input  logic [DATA_W-1:0]          req_b,
  input  logic [2:0]                 req_op,
  input  logic                       req_len_ok,
  input  logic                       req_crc_ok,
  input  logic                       rsp_valid,
  input  logic                       rsp_err,
  input  logic [DATA_W-1:0]          rsp_data,
  input  logic [5:0]                 rsp_flags,
  output logic                       verdict_vld,
  output logic                       verdict_fail,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic                       orphan_err,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_VAL   = TO_W'(TIMEOUT);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef struct packed {
    logic              err;
    logic [5:0]        flags;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef enum logic [1:0] {WD_IDLE, WD_WAIT, WD_EXPIRED} wd_t;

  // Unused fields stay zero so a stored entry is fully determined by the request.
  function automatic exp_t calc_exp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                    input logic [2:0] op, input logic len_ok, input logic crc_ok);
    exp_t e;
    e = '0;
    if (!len_ok) begin
      e.err   = 1'b1;
      e.flags = 6'b100100;
    end else if (!crc_ok) begin
      e.err   = 1'b1;
      e.flags = 6'b010010;
    end else begin
      case (op)
        3'b000:  e.data = a & b;
        3'b001:  e.data = a + b;
        3'b100:  e.data = a | b;
        3'b101:  e.data = b - a;
        default: begin
          e.err   = 1'b1;
          e.flags = 6'b001001;
        end
      endcase
    end
    return e;
  endfunction

  exp_t             mem [DEPTH];
  exp_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             full, empty, push, pop, orphan, match;

  wd_t              wd_q, wd_nxt;
  logic [TO_W-1:0]  wd_cnt_q, wd_cnt_nxt;
  logic             set_timeout;

  assign full      = (level_q == LVL_FULL);
  assign empty     = (level_q == '0);
  assign req_ready = !full;
  assign level     = level_q;

  assign push   = req_valid && !full && !clear;
  assign pop    = rsp_valid && !empty && !clear;
  // An empty FIFO is judged on its own: a same-cycle push is not a bypass.
  assign orphan = rsp_valid && empty && !clear;

  assign head  = mem[rd_ptr];
  assign match = (head.err == rsp_err) &&
                 (rsp_err ? (head.flags == rsp_flags) : (head.data == rsp_data));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= calc_exp(req_a, req_b, req_op, req_len_ok, req_crc_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verdict_vld  <= 1'b0;
      verdict_fail <= 1'b0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      orphan_err   <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (clear) begin
      verdict_vld  <= 1'b0;
      verdict_fail <= 1'b0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      orphan_err   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      verdict_vld  <= rsp_valid;
      verdict_fail <= orphan || (pop && !match);
      if (pop && match && !(&pass_cnt))                  pass_cnt <= pass_cnt + 1'b1;
      if ((orphan || (pop && !match)) && !(&fail_cnt))   fail_cnt <= fail_cnt + 1'b1;
      if (orphan)      orphan_err  <= 1'b1;
      if (set_timeout) timeout_err <= 1'b1;
    end
  end

  // Watchdog: measures how long the oldest outstanding expectation has waited.
  always_comb begin
    wd_nxt      = wd_q;
    wd_cnt_nxt  = wd_cnt_q;
    set_timeout = 1'b0;
    if (TIMEOUT == 0) begin
      wd_nxt     = WD_IDLE;
      wd_cnt_nxt = '0;
    end else begin
      case (wd_q)
        WD_IDLE: begin
          wd_cnt_nxt = '0;
          if (!empty) wd_nxt = WD_WAIT;
        end
        WD_WAIT: begin
          if (empty) begin
            wd_nxt     = WD_IDLE;
            wd_cnt_nxt = '0;
          end else if (pop) begin
            wd_cnt_nxt = '0;
          end else if (wd_cnt_q == TO_VAL) begin
            wd_nxt      = WD_EXPIRED;
            set_timeout = 1'b1;
          end else begin
            wd_cnt_nxt = wd_cnt_q + 1'b1;
          end
        end
        WD_EXPIRED: begin
          wd_cnt_nxt = '0;
          if (empty) wd_nxt = WD_IDLE;
        end
        default: begin
          wd_nxt     = WD_IDLE;
          wd_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q     <= WD_IDLE;
      wd_cnt_q <= '0;
    end else if (clear) begin
      wd_q     <= WD_IDLE;
      wd_cnt_q <= '0;
    end else begin
      wd_q     <= wd_nxt;
      wd_cnt_q <= wd_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: vector table plus hand-written FIFO, orphan,
// clear, timeout and reset sequences; verdicts are matched through a scoreboard queue.
module tb_alu_result_checker;

  localparam int DW = 32;
  localparam int NV = 12;
  localparam logic [2:0] OP_AND = 3'b000, OP_ADD = 3'b001, OP_OR = 3'b100,
                         OP_SUB = 3'b101, OP_BAD = 3'b010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [2:0]    req_op = '0;
  logic          req_len_ok = 1'b0, req_crc_ok = 1'b0;
  logic          rsp_valid = 1'b0, rsp_err = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic [5:0]    rsp_flags = '0;
  logic          verdict_vld, verdict_fail, orphan_err, timeout_err;
  logic [15:0]   pass_cnt, fail_cnt;
  logic [3:0]    level;

  alu_result_checker #(.DATA_W(DW), .DEPTH(8), .CNT_W(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_len_ok(req_len_ok), .req_crc_ok(req_crc_ok),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .verdict_vld(verdict_vld), .verdict_fail(verdict_fail),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .orphan_err(orphan_err), .timeout_err(timeout_err), .level(level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a, b;
    logic          lok, cok, rerr;
    logic [DW-1:0] rdata;
    logic [5:0]    rflags;
    logic          fail;
  } vec_t;

  typedef struct {
    logic fail;
    int   cyc;
  } sb_t;

  vec_t vt [NV];
  sb_t  sbq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Verdicts must appear exactly one cycle after the response, in order.
  sb_t s;
  always @(negedge clk) begin
    if (rst_n && verdict_vld) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_verdict: got verdict_vld=1 expected none (cycle %0d)", cyc);
      end else begin
        s = sbq.pop_front();
        chk("verdict_fail", 64'(verdict_fail), 64'(s.fail));
        chk("verdict_latency", 64'(cyc), 64'(s.cyc));
      end
    end
  end

  task automatic drive(input logic clr, input logic pv, input logic [2:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic lok, input logic cok, input logic rv, input logic rerr,
                       input logic [DW-1:0] rd, input logic [5:0] rf, input logic efail);
    @(negedge clk);
    clear = clr; req_valid = pv; req_op = op; req_a = a; req_b = b;
    req_len_ok = lok; req_crc_ok = cok;
    rsp_valid = rv; rsp_err = rerr; rsp_data = rd; rsp_flags = rf;
    if (rv && !clr) sbq.push_back('{efail, cyc + 1});
  endtask

  task automatic push(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic lok, input logic cok);
    drive(1'b0, 1'b1, op, a, b, lok, cok, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rsp(input logic rerr, input logic [DW-1:0] rd, input logic [5:0] rf,
                     input logic efail);
    drive(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0, 1'b1, rerr, rd, rf, efail);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_verdict_vld"},  64'(verdict_vld), 64'd0);
    chk({tag, "_verdict_fail"}, 64'(verdict_fail), 64'd0);
    chk({tag, "_pass_cnt"},     64'(pass_cnt), 64'd0);
    chk({tag, "_fail_cnt"},     64'(fail_cnt), 64'd0);
    chk({tag, "_orphan_err"},   64'(orphan_err), 64'd0);
    chk({tag, "_timeout_err"},  64'(timeout_err), 64'd0);
    chk({tag, "_level"},        64'(level), 64'd0);
    chk({tag, "_req_ready"},    64'(req_ready), 64'd1);
  endtask

  initial begin
    int exp_pass, exp_fail, n;

    //        op      a             b             lok   cok   rerr  rdata         rflags      fail
    vt[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,        1'b1, 1'b1, 1'b0, 32'h0,        6'b000000, 1'b0};
    vt[1]  = '{OP_SUB, 32'h5,         32'h3,        1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 6'b000000, 1'b0};
    vt[2]  = '{OP_SUB, 32'h5,         32'h3,        1'b1, 1'b1, 1'b0, 32'h2,        6'b000000, 1'b1};
    vt[3]  = '{OP_ADD, 32'h1,         32'h2,        1'b0, 1'b0, 1'b1, 32'h0,        6'b010010, 1'b1};
    vt[4]  = '{OP_ADD, 32'h1,         32'h2,        1'b0, 1'b0, 1'b1, 32'h0,        6'b100100, 1'b0};
    vt[5]  = '{OP_OR,  32'h1,         32'h2,        1'b1, 1'b0, 1'b1, 32'h0,        6'b010010, 1'b0};
    vt[6]  = '{OP_BAD, 32'h1,         32'h2,        1'b1, 1'b1, 1'b1, 32'h0,        6'b001001, 1'b0};
    vt[7]  = '{OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 1'b1, 1'b0, 32'h00F0_1234, 6'b000000, 1'b0};
    vt[8]  = '{OP_OR,  32'hA500_0000, 32'h0000_005A, 1'b1, 1'b1, 1'b0, 32'hA500_005A, 6'b000000, 1'b0};
    vt[9]  = '{OP_ADD, 32'h3,         32'h4,        1'b1, 1'b1, 1'b1, 32'h7,        6'b000000, 1'b1};
    vt[10] = '{OP_ADD, 32'h3,         32'h4,        1'b1, 1'b0, 1'b0, 32'h7,        6'b000000, 1'b1};
    vt[11] = '{OP_ADD, 32'h7FFF_FFFF, 32'h1,        1'b1, 1'b1, 1'b0, 32'h8000_0000, 6'b000000, 1'b0};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle();

    exp_pass = 0;
    exp_fail = 0;
    for (int i = 0; i < NV; i++) begin
      push(vt[i].op, vt[i].a, vt[i].b, vt[i].lok, vt[i].cok);
      rsp(vt[i].rerr, vt[i].rdata, vt[i].rflags, vt[i].fail);
      if (vt[i].fail) exp_fail++; else exp_pass++;
    end
    idle();
    idle();
    chk("table_pass_cnt", 64'(pass_cnt), 64'(exp_pass));
    chk("table_fail_cnt", 64'(fail_cnt), 64'(exp_fail));
    chk("table_level", 64'(level), 64'd0);

    // Clear with a response present: no verdict, ready stays high.
    drive(1'b1, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("clear_req_ready", 64'(req_ready), 64'd1);
    idle();
    chk("clear_pass_cnt", 64'(pass_cnt), 64'd0);
    chk("clear_fail_cnt", 64'(fail_cnt), 64'd0);

    for (int i = 0; i < 8; i++) push(OP_ADD, DW'(i), DW'(3 * i), 1'b1, 1'b1);
    idle();
    chk("full_level", 64'(level), 64'd8);
    chk("full_req_ready", 64'(req_ready), 64'd0);
    push(OP_ADD, 32'd100, 32'd100, 1'b1, 1'b1);
    idle();
    chk("full_ignored_level", 64'(level), 64'd8);
    rsp(1'b0, 32'd0, '0, 1'b0);
    drive(1'b0, 1'b1, OP_ADD, 32'd8, 32'd24, 1'b1, 1'b1, 1'b1, 1'b0, 32'd4, '0, 1'b0);
    idle();
    chk("push_pop_level", 64'(level), 64'd7);
    for (int i = 2; i <= 8; i++) rsp(1'b0, DW'(4 * i), '0, 1'b0);
    idle();
    idle();
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_pass_cnt", 64'(pass_cnt), 64'd9);
    chk("drain_fail_cnt", 64'(fail_cnt), 64'd0);

    rsp(1'b0, 32'd0, '0, 1'b1);
    idle();
    chk("orphan_err", 64'(orphan_err), 64'd1);
    chk("orphan_fail_cnt", 64'(fail_cnt), 64'd1);
    // Orphan response alongside a push: the push is kept, not matched.
    drive(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd2, '0, 1'b1);
    idle();
    chk("orphan_push_level", 64'(level), 64'd1);
    chk("orphan_push_fail_cnt", 64'(fail_cnt), 64'd2);
    rsp(1'b0, 32'd2, '0, 1'b0);
    idle();
    chk("orphan_after_pass_cnt", 64'(pass_cnt), 64'd10);
    drive(1'b1, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    idle();
    chk("clear2_orphan_err", 64'(orphan_err), 64'd0);
    chk("clear2_fail_cnt", 64'(fail_cnt), 64'd0);
    chk("clear2_pass_cnt", 64'(pass_cnt), 64'd0);

    push(OP_ADD, 32'd1, 32'd1, 1'b1, 1'b1);
    repeat (10) idle();
    chk("timeout_early", 64'(timeout_err), 64'd0);
    n = 0;
    while (n < 40 && !timeout_err) begin
      idle();
      n++;
    end
    chk("timeout_err", 64'(timeout_err), 64'd1);
    rsp(1'b0, 32'd2, '0, 1'b0);
    idle();
    idle();
    chk("timeout_sticky", 64'(timeout_err), 64'd1);
    chk("timeout_drain_level", 64'(level), 64'd0);

    push(OP_ADD, 32'd1, 32'd1, 1'b1, 1'b1);
    repeat (5) idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();
    chk("post_reset_level", 64'(level), 64'd0);
    chk("post_reset_timeout", 64'(timeout_err), 64'd0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "bench time limit");
  end

endmodule
